// File: rtl/eth_frame_log_arbiter_if.sv
// Stream bundle between the frame-detector extract units and the log arbiter.
// master = the arbiter side (drives the log stream and upstream readies).
interface eth_frame_log_arbiter_if #(
    parameter int C_NUM_SOURCES    = 2,
    parameter int C_AXIS_LOG_WIDTH = 64
);
    localparam int TDEST_W = (C_NUM_SOURCES > 1) ? $clog2(C_NUM_SOURCES) : 1;

    logic [120*C_NUM_SOURCES-1:0]              s_axis_ctl_tdata;
    logic [C_NUM_SOURCES-1:0]                  s_axis_ctl_tvalid;
    logic [C_NUM_SOURCES-1:0]                  s_axis_ctl_tready;
    logic [C_AXIS_LOG_WIDTH*C_NUM_SOURCES-1:0] s_axis_frame_tdata;
    logic [C_NUM_SOURCES-1:0]                  s_axis_frame_tvalid;
    logic [C_NUM_SOURCES-1:0]                  s_axis_frame_tready;
    logic [C_AXIS_LOG_WIDTH-1:0]               m_axis_tdata;
    logic [TDEST_W-1:0]                        m_axis_tdest;
    logic                                      m_axis_tlast;
    logic                                      m_axis_tvalid;
    logic                                      m_axis_tready;

    modport master (
        input  s_axis_ctl_tdata, s_axis_ctl_tvalid,
        output s_axis_ctl_tready,
        input  s_axis_frame_tdata, s_axis_frame_tvalid,
        output s_axis_frame_tready,
        output m_axis_tdata, m_axis_tdest, m_axis_tlast, m_axis_tvalid,
        input  m_axis_tready
    );

    modport slave (
        output s_axis_ctl_tdata, s_axis_ctl_tvalid,
        input  s_axis_ctl_tready,
        output s_axis_frame_tdata, s_axis_frame_tvalid,
        input  s_axis_frame_tready,
        input  m_axis_tdata, m_axis_tdest, m_axis_tlast, m_axis_tvalid,
        output m_axis_tready
    );
endinterface

// File: rtl/eth_frame_log_arbiter.sv
// Round-robin merge of per-detector control records and frame words into one
// log stream; records with no matched script are drained and counted.
module eth_frame_log_arbiter #(
    parameter int C_NUM_SOURCES    = 2,
    parameter int C_NUM_SCRIPTS    = 4,
    parameter int C_AXIS_LOG_WIDTH = 64
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   enable,
    eth_frame_log_arbiter_if.master bus,
    output logic [31:0]            dropped_count
);
    localparam int unsigned NSRC    = C_NUM_SOURCES;
    localparam int          W       = C_AXIS_LOG_WIDTH;
    localparam int          B       = W / 8;
    localparam int          LOG2B   = $clog2(B);
    localparam int          H       = 128 / W;
    localparam int          HIDX_W  = (H > 1) ? $clog2(H) : 1;
    localparam int          TDEST_W = (C_NUM_SOURCES > 1) ? $clog2(C_NUM_SOURCES) : 1;

    typedef enum logic [1:0] {ST_IDLE, ST_HEADER, ST_DATA, ST_DRAIN} state_t;

    state_t             state;
    logic [TDEST_W-1:0] rr_ptr;
    logic [TDEST_W-1:0] grant;
    logic [127:0]       hdr_reg;
    logic [15:0]        remaining;
    logic [HIDX_W-1:0]  hidx;

    logic               found;
    logic [TDEST_W-1:0] sel;
    logic [119:0]       ctl_sel;
    logic [16:0]        size17;
    logic [15:0]        d_sel;
    logic               matched_nz;
    logic               grant_now;

    logic [NSRC-1:0]    ctl_tready;
    logic [NSRC-1:0]    frame_tready;
    logic [W-1:0]       m_data;
    logic [TDEST_W-1:0] m_dest;
    logic               m_last;
    logic               m_valid;

    function automatic logic [TDEST_W-1:0] wrap_next(input logic [TDEST_W-1:0] g);
        if (int'(g) >= C_NUM_SOURCES - 1)
            return '0;
        return g + TDEST_W'(1);
    endfunction

    // First valid source at or after rr_ptr, wrapping.
    always_comb begin
        int unsigned        idx;
        logic [TDEST_W-1:0] cand;
        found = 1'b0;
        sel   = '0;
        idx   = 0;
        cand  = '0;
        for (int unsigned i = 0; i < NSRC; i++) begin
            idx = 32'(rr_ptr) + i;
            if (idx >= NSRC)
                idx = idx - NSRC;
            cand = TDEST_W'(idx);
            if (!found && bus.s_axis_ctl_tvalid[cand]) begin
                found = 1'b1;
                sel   = cand;
            end
        end
    end

    // 17-bit sum keeps SIZE = 0xFFFF from wrapping before the shift.
    assign ctl_sel    = bus.s_axis_ctl_tdata[int'(sel)*120 +: 120];
    assign size17     = {1'b0, ctl_sel[111:96]} + 17'(B - 1);
    assign d_sel      = 16'(size17 >> LOG2B);
    assign matched_nz = |ctl_sel[C_NUM_SCRIPTS+111:112];
    assign grant_now  = (state == ST_IDLE) && enable && found && !rst;

    always_comb begin
        ctl_tready   = '0;
        frame_tready = '0;
        m_data       = '0;
        m_dest       = '0;
        m_last       = 1'b0;
        m_valid      = 1'b0;
        case (state)
            ST_IDLE: begin
                if (grant_now)
                    ctl_tready[sel] = 1'b1;
            end
            ST_HEADER: begin
                m_valid = 1'b1;
                m_data  = hdr_reg[int'(hidx)*W +: W];
                m_dest  = grant;
                m_last  = (hidx == HIDX_W'(H - 1)) && (remaining == 16'd0);
            end
            ST_DATA: begin
                m_valid             = bus.s_axis_frame_tvalid[grant];
                m_data              = bus.s_axis_frame_tdata[int'(grant)*W +: W];
                m_dest              = grant;
                m_last              = (remaining == 16'd1);
                frame_tready[grant] = bus.m_axis_tready;
            end
            ST_DRAIN: begin
                frame_tready[grant] = 1'b1;
            end
            default: ;
        endcase
    end

    assign bus.s_axis_ctl_tready   = ctl_tready;
    assign bus.s_axis_frame_tready = frame_tready;
    assign bus.m_axis_tdata        = m_data;
    assign bus.m_axis_tdest        = m_dest;
    assign bus.m_axis_tlast        = m_last;
    assign bus.m_axis_tvalid       = m_valid;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= ST_IDLE;
            rr_ptr        <= '0;
            grant         <= '0;
            hdr_reg       <= '0;
            remaining     <= '0;
            hidx          <= '0;
            dropped_count <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (enable && found) begin
                        grant     <= sel;
                        hdr_reg   <= {8'h00, ctl_sel};
                        remaining <= d_sel;
                        hidx      <= '0;
                        if (matched_nz) begin
                            state <= ST_HEADER;
                        end else if (d_sel != 16'd0) begin
                            state <= ST_DRAIN;
                        end else begin
                            dropped_count <= dropped_count + 32'd1;
                            rr_ptr        <= wrap_next(sel);
                        end
                    end
                end
                ST_HEADER: begin
                    if (bus.m_axis_tready) begin
                        if (hidx == HIDX_W'(H - 1)) begin
                            hidx <= '0;
                            if (remaining == 16'd0) begin
                                state  <= ST_IDLE;
                                rr_ptr <= wrap_next(grant);
                            end else begin
                                state <= ST_DATA;
                            end
                        end else begin
                            hidx <= hidx + HIDX_W'(1);
                        end
                    end
                end
                ST_DATA: begin
                    if (bus.s_axis_frame_tvalid[grant] && bus.m_axis_tready) begin
                        remaining <= remaining - 16'd1;
                        if (remaining == 16'd1) begin
                            state  <= ST_IDLE;
                            rr_ptr <= wrap_next(grant);
                        end
                    end
                end
                ST_DRAIN: begin
                    if (bus.s_axis_frame_tvalid[grant]) begin
                        remaining <= remaining - 16'd1;
                        if (remaining == 16'd1) begin
                            state         <= ST_IDLE;
                            rr_ptr        <= wrap_next(grant);
                            dropped_count <= dropped_count + 32'd1;
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_eth_frame_log_arbiter.sv
// Randomised bench: per-source record/frame queues feed the arbiter and the
// expected per-source log stream is built directly from each record's fields.
module tb_eth_frame_log_arbiter;
    localparam int N = 2;
    localparam int W = 64;
    localparam int B = W / 8;
    localparam int H = 128 / W;

    typedef struct packed {
        logic         last;
        logic [W-1:0] data;
    } ow_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        enable;
    logic [31:0] dropped_count;

    bit   rand_mode;
    int   total, bad, exp_drop;
    int   cyc, last_ctl_cyc, first_out_cyc, drop_cyc, tv_cnt, ctl_rdy_cnt;
    int   frm_rdy_cnt [N];
    logic [31:0] prev_drop;

    logic [119:0] ctl_q   [N][$];
    logic [W-1:0] frm_q   [N][$];
    ow_t          got_out [N][$];
    ow_t          exp_out [N][$];
    int           dest_seq[$];

    always #5 clk = ~clk;

    eth_frame_log_arbiter_if #(.C_NUM_SOURCES(N), .C_AXIS_LOG_WIDTH(W)) bus ();

    eth_frame_log_arbiter #(
        .C_NUM_SOURCES(N),
        .C_NUM_SCRIPTS(4),
        .C_AXIS_LOG_WIDTH(W)
    ) dut (
        .clk(clk),
        .rst(rst),
        .enable(enable),
        .bus(bus),
        .dropped_count(dropped_count)
    );

    // Bus model: sample handshakes on the falling edge, pop and redrive after the rising edge.
    initial begin
        logic [N-1:0] ch, fh;
        forever begin
            @(negedge clk);
            cyc++;
            ch = bus.s_axis_ctl_tvalid & bus.s_axis_ctl_tready;
            fh = bus.s_axis_frame_tvalid & bus.s_axis_frame_tready;
            if (ch != '0) last_ctl_cyc = cyc;
            if (bus.s_axis_ctl_tready != '0) ctl_rdy_cnt++;
            for (int s = 0; s < N; s++)
                if (bus.s_axis_frame_tready[s]) frm_rdy_cnt[s]++;
            if (bus.m_axis_tvalid) tv_cnt++;
            if (bus.m_axis_tvalid && bus.m_axis_tready) begin
                got_out[int'(bus.m_axis_tdest)].push_back({bus.m_axis_tlast, bus.m_axis_tdata});
                if (first_out_cyc < 0) first_out_cyc = cyc;
                if (bus.m_axis_tlast) dest_seq.push_back(int'(bus.m_axis_tdest));
            end
            if (dropped_count != prev_drop) begin
                drop_cyc  = cyc;
                prev_drop = dropped_count;
            end
            @(posedge clk);
            #1;
            for (int s = 0; s < N; s++) begin
                if (ch[s] && ctl_q[s].size() > 0) void'(ctl_q[s].pop_front());
                if (fh[s] && frm_q[s].size() > 0) void'(frm_q[s].pop_front());
                bus.s_axis_ctl_tvalid[s]        = (ctl_q[s].size() > 0);
                bus.s_axis_ctl_tdata[s*120 +: 120] = (ctl_q[s].size() > 0) ? ctl_q[s][0] : '0;
                bus.s_axis_frame_tvalid[s]      = (frm_q[s].size() > 0) && (!rand_mode || ($urandom % 4 != 0));
                bus.s_axis_frame_tdata[s*W +: W] = (frm_q[s].size() > 0) ? frm_q[s][0] : '0;
            end
            bus.m_axis_tready = rand_mode ? 1'($urandom % 2) : 1'b1;
        end
    end

    // Queue one record and its frame words; append what the log stream must show for it.
    task automatic add_rec(input int s, input logic [3:0] m, input int size);
        logic [119:0] c;
        logic [127:0] h;
        logic [W-1:0] w;
        int d;
        c           = '0;
        c[63:0]     = {$urandom, $urandom};
        c[95:64]    = $urandom;
        c[111:96]   = size[15:0];
        c[115:112]  = m;
        c[119:116]  = 4'($urandom);
        d = (size + B - 1) / B;
        h = {8'h00, c};
        ctl_q[s].push_back(c);
        if (m != 4'h0) begin
            for (int i = 0; i < H; i++)
                exp_out[s].push_back({(i == H - 1) && (d == 0), h[i*W +: W]});
        end else begin
            exp_drop++;
        end
        for (int i = 0; i < d; i++) begin
            w = {$urandom, $urandom};
            frm_q[s].push_back(w);
            if (m != 4'h0) exp_out[s].push_back({(i == d - 1), w});
        end
    endtask

    task automatic wait_idle(input int budget, output bit ok);
        bit busy;
        ok = 1'b0;
        for (int n = 0; n < budget; n++) begin
            @(posedge clk); #3;
            busy = 1'b0;
            for (int s = 0; s < N; s++)
                if (ctl_q[s].size() != 0 || frm_q[s].size() != 0) busy = 1'b1;
            if (!busy) begin
                ok = 1'b1;
                break;
            end
        end
        repeat (2*H + 4) begin @(posedge clk); #3; end
    endtask

    task automatic test_reset;
        repeat (3) @(posedge clk);
        #3;
        total++; if (bus.m_axis_tvalid !== 1'b0) begin bad++; $display("FAIL reset_tvalid: got %b want 0", bus.m_axis_tvalid); end
        total++; if (bus.m_axis_tdata !== '0) begin bad++; $display("FAIL reset_tdata: got %h want 0", bus.m_axis_tdata); end
        total++; if (bus.m_axis_tdest !== '0 || bus.m_axis_tlast !== 1'b0) begin bad++; $display("FAIL reset_tdest_tlast: got %b/%b want 0/0", bus.m_axis_tdest, bus.m_axis_tlast); end
        total++; if (bus.s_axis_ctl_tready !== '0 || bus.s_axis_frame_tready !== '0) begin bad++; $display("FAIL reset_treadys: got %b/%b want 0/0", bus.s_axis_ctl_tready, bus.s_axis_frame_tready); end
        total++; if (dropped_count !== 32'd0) begin bad++; $display("FAIL reset_dropped: got %0d want 0", dropped_count); end
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #3;
        total++; if (bus.m_axis_tvalid !== 1'b0 || bus.s_axis_ctl_tready !== '0) begin bad++; $display("FAIL idle_quiet: got tvalid=%b ctl_tready=%b want 0/0", bus.m_axis_tvalid, bus.s_axis_ctl_tready); end
    endtask

    task automatic test_round_robin;
        bit ok;
        add_rec(0, 4'h1, 8); add_rec(0, 4'h1, 8);
        add_rec(1, 4'h1, 8); add_rec(1, 4'h1, 8);
        wait_idle(200, ok);
        total++; if (!ok) begin bad++; $display("FAIL rr_timeout: got busy want idle"); end
        total++; if (dest_seq.size() !== 4) begin bad++; $display("FAIL rr_records: got %0d want 4", dest_seq.size()); end
        for (int i = 0; i < dest_seq.size() && i < 4; i++) begin
            total++; if (dest_seq[i] !== i % 2) begin bad++; $display("FAIL rr_grant[%0d]: got %0d want %0d", i, dest_seq[i], i % 2); end
        end
        for (int s = 0; s < N; s++) begin
            total++; if (got_out[s].size() !== exp_out[s].size()) begin bad++; $display("FAIL rr_len src%0d: got %0d want %0d", s, got_out[s].size(), exp_out[s].size()); end
            for (int i = 0; i < got_out[s].size() && i < exp_out[s].size(); i++) begin
                total++; if (got_out[s][i] !== exp_out[s][i]) begin bad++; $display("FAIL rr_word src%0d[%0d]: got %0b/%h want %0b/%h", s, i, got_out[s][i].last, got_out[s][i].data, exp_out[s][i].last, exp_out[s][i].data); end
            end
            got_out[s].delete(); exp_out[s].delete();
        end
        dest_seq.delete();
    endtask

    task automatic test_basic;
        bit ok;
        first_out_cyc = -1;
        add_rec(0, 4'h1, 20);
        wait_idle(200, ok);
        total++; if (!ok) begin bad++; $display("FAIL basic_timeout: got busy want idle"); end
        total++; if (first_out_cyc - last_ctl_cyc !== 1) begin bad++; $display("FAIL basic_latency: got %0d want 1", first_out_cyc - last_ctl_cyc); end
        total++; if (dest_seq.size() !== 1 || dest_seq[0] !== 0) begin bad++; $display("FAIL basic_tdest: got %0d records want one from src0", dest_seq.size()); end
        total++; if (got_out[0].size() !== 5) begin bad++; $display("FAIL basic_len: got %0d want 5", got_out[0].size()); end
        for (int i = 0; i < got_out[0].size() && i < exp_out[0].size(); i++) begin
            total++; if (got_out[0][i] !== exp_out[0][i]) begin bad++; $display("FAIL basic_word[%0d]: got %0b/%h want %0b/%h", i, got_out[0][i].last, got_out[0][i].data, exp_out[0][i].last, exp_out[0][i].data); end
        end
        got_out[0].delete(); exp_out[0].delete(); dest_seq.delete();
    endtask

    task automatic test_drop;
        bit ok;
        int tv0;
        tv0 = tv_cnt;
        add_rec(1, 4'h0, 17);
        wait_idle(200, ok);
        total++; if (!ok) begin bad++; $display("FAIL drop_timeout: got busy want idle"); end
        total++; if (tv_cnt !== tv0) begin bad++; $display("FAIL drop_tvalid: got %0d valid cycles want 0", tv_cnt - tv0); end
        total++; if (dropped_count !== 32'(exp_drop)) begin bad++; $display("FAIL drop_count: got %0d want %0d", dropped_count, exp_drop); end
        add_rec(1, 4'h1, 24);
        wait_idle(200, ok);
        total++; if (got_out[1].size() !== exp_out[1].size()) begin bad++; $display("FAIL drop_next_len: got %0d want %0d", got_out[1].size(), exp_out[1].size()); end
        for (int i = 0; i < got_out[1].size() && i < exp_out[1].size(); i++) begin
            total++; if (got_out[1][i] !== exp_out[1][i]) begin bad++; $display("FAIL drop_next_word[%0d]: got %0b/%h want %0b/%h", i, got_out[1][i].last, got_out[1][i].data, exp_out[1][i].last, exp_out[1][i].data); end
        end
        got_out[1].delete(); exp_out[1].delete(); dest_seq.delete();
    endtask

    task automatic test_size_zero;
        bit ok;
        int f0, tv0;
        f0 = frm_rdy_cnt[0];
        add_rec(0, 4'h2, 0);
        wait_idle(100, ok);
        total++; if (!ok) begin bad++; $display("FAIL zero_timeout: got busy want idle"); end
        total++; if (frm_rdy_cnt[0] !== f0) begin bad++; $display("FAIL zero_frame_tready: got %0d cycles want 0", frm_rdy_cnt[0] - f0); end
        total++; if (got_out[0].size() !== 2) begin bad++; $display("FAIL zero_len: got %0d want 2", got_out[0].size()); end
        for (int i = 0; i < got_out[0].size() && i < exp_out[0].size(); i++) begin
            total++; if (got_out[0][i] !== exp_out[0][i]) begin bad++; $display("FAIL zero_word[%0d]: got %0b/%h want %0b/%h", i, got_out[0][i].last, got_out[0][i].data, exp_out[0][i].last, exp_out[0][i].data); end
        end
        got_out[0].delete(); exp_out[0].delete(); dest_seq.delete();
        tv0 = tv_cnt;
        add_rec(0, 4'h0, 0);
        wait_idle(100, ok);
        total++; if (dropped_count !== 32'(exp_drop)) begin bad++; $display("FAIL zero_drop_count: got %0d want %0d", dropped_count, exp_drop); end
        total++; if (drop_cyc - last_ctl_cyc !== 1) begin bad++; $display("FAIL zero_drop_latency: got %0d want 1", drop_cyc - last_ctl_cyc); end
        total++; if (tv_cnt !== tv0) begin bad++; $display("FAIL zero_drop_tvalid: got %0d want 0", tv_cnt - tv0); end
    endtask

    task automatic test_enable;
        bit ok;
        int c0, tv0, n;
        enable = 1'b0;
        c0 = ctl_rdy_cnt; tv0 = tv_cnt;
        add_rec(0, 4'h1, 8);
        repeat (10) begin @(posedge clk); #3; end
        total++; if (ctl_rdy_cnt !== c0) begin bad++; $display("FAIL en_ctl_tready: got %0d pulses want 0", ctl_rdy_cnt - c0); end
        total++; if (tv_cnt !== tv0) begin bad++; $display("FAIL en_tvalid: got %0d want 0", tv_cnt - tv0); end
        enable = 1'b1;
        wait_idle(200, ok);
        add_rec(1, 4'h1, 40);
        n = 0;
        while (ctl_q[1].size() != 0 && n < 50) begin @(posedge clk); #3; n++; end
        enable = 1'b0;
        wait_idle(200, ok);
        enable = 1'b1;
        total++; if (!ok) begin bad++; $display("FAIL en_midrecord_timeout: got busy want idle"); end
        for (int s = 0; s < N; s++) begin
            total++; if (got_out[s].size() !== exp_out[s].size()) begin bad++; $display("FAIL en_len src%0d: got %0d want %0d", s, got_out[s].size(), exp_out[s].size()); end
            for (int i = 0; i < got_out[s].size() && i < exp_out[s].size(); i++) begin
                total++; if (got_out[s][i] !== exp_out[s][i]) begin bad++; $display("FAIL en_word src%0d[%0d]: got %0b/%h want %0b/%h", s, i, got_out[s][i].last, got_out[s][i].data, exp_out[s][i].last, exp_out[s][i].data); end
            end
            got_out[s].delete(); exp_out[s].delete();
        end
        dest_seq.delete();
    endtask

    task automatic test_random;
        bit ok;
        rand_mode = 1'b1;
        for (int r = 0; r < 12; r++)
            add_rec(int'($urandom % N), ($urandom % 5 == 0) ? 4'h0 : 4'($urandom_range(1, 15)), int'($urandom_range(1, 1518)));
        wait_idle(20000, ok);
        rand_mode = 1'b0;
        total++; if (!ok) begin bad++; $display("FAIL rand_timeout: got busy want idle"); end
        total++; if (dropped_count !== 32'(exp_drop)) begin bad++; $display("FAIL rand_drop_count: got %0d want %0d", dropped_count, exp_drop); end
        for (int s = 0; s < N; s++) begin
            total++; if (got_out[s].size() !== exp_out[s].size()) begin bad++; $display("FAIL rand_len src%0d: got %0d want %0d", s, got_out[s].size(), exp_out[s].size()); end
            for (int i = 0; i < got_out[s].size() && i < exp_out[s].size(); i++) begin
                total++; if (got_out[s][i] !== exp_out[s][i]) begin bad++; $display("FAIL rand_word src%0d[%0d]: got %0b/%h want %0b/%h", s, i, got_out[s][i].last, got_out[s][i].data, exp_out[s][i].last, exp_out[s][i].data); end
            end
            got_out[s].delete(); exp_out[s].delete();
        end
        dest_seq.delete();
    endtask

    task automatic test_reset_mid;
        bit ok;
        int n;
        add_rec(0, 4'h1, 8);
        wait_idle(200, ok);
        got_out[0].delete(); exp_out[0].delete(); dest_seq.delete();
        add_rec(0, 4'h1, 64);
        n = 0;
        while (got_out[0].size() < 6 && n < 50) begin @(posedge clk); #3; n++; end
        total++; if (got_out[0].size() !== 6) begin bad++; $display("FAIL rstmid_reach: got %0d words want 6", got_out[0].size()); end
        rst = 1'b1;
        #1;
        total++; if (bus.m_axis_tvalid !== 1'b0 || bus.m_axis_tlast !== 1'b0) begin bad++; $display("FAIL rstmid_tvalid_tlast: got %b/%b want 0/0", bus.m_axis_tvalid, bus.m_axis_tlast); end
        total++; if (bus.m_axis_tdata !== '0 || bus.m_axis_tdest !== '0) begin bad++; $display("FAIL rstmid_tdata_tdest: got %h/%b want 0/0", bus.m_axis_tdata, bus.m_axis_tdest); end
        total++; if (bus.s_axis_frame_tready !== '0 || bus.s_axis_ctl_tready !== '0) begin bad++; $display("FAIL rstmid_treadys: got %b/%b want 0/0", bus.s_axis_frame_tready, bus.s_axis_ctl_tready); end
        total++; if (dropped_count !== 32'd0) begin bad++; $display("FAIL rstmid_dropped: got %0d want 0", dropped_count); end
        for (int s = 0; s < N; s++) begin
            ctl_q[s].delete(); frm_q[s].delete(); got_out[s].delete(); exp_out[s].delete();
        end
        dest_seq.delete();
        exp_drop = 0;
        repeat (2) @(posedge clk);
        #3;
        rst = 1'b0;
        add_rec(1, 4'h1, 8);
        add_rec(0, 4'h1, 8);
        wait_idle(200, ok);
        total++; if (dest_seq.size() !== 2 || dest_seq[0] !== 0) begin bad++; $display("FAIL rstmid_rr_ptr: got %0d records first=%0d want 2 first=0", dest_seq.size(), (dest_seq.size() > 0) ? dest_seq[0] : -1); end
        for (int s = 0; s < N; s++) begin
            total++; if (got_out[s].size() !== exp_out[s].size()) begin bad++; $display("FAIL rstmid_len src%0d: got %0d want %0d", s, got_out[s].size(), exp_out[s].size()); end
            for (int i = 0; i < got_out[s].size() && i < exp_out[s].size(); i++) begin
                total++; if (got_out[s][i] !== exp_out[s][i]) begin bad++; $display("FAIL rstmid_word src%0d[%0d]: got %0b/%h want %0b/%h", s, i, got_out[s][i].last, got_out[s][i].data, exp_out[s][i].last, exp_out[s][i].data); end
            end
        end
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: got no finish want finish before time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        total = 0; bad = 0; exp_drop = 0;
        cyc = 0; last_ctl_cyc = 0; first_out_cyc = -1; drop_cyc = 0;
        tv_cnt = 0; ctl_rdy_cnt = 0; prev_drop = '0;
        for (int s = 0; s < N; s++) frm_rdy_cnt[s] = 0;
        rand_mode = 1'b0;
        rst = 1'b1;
        enable = 1'b1;
        bus.s_axis_ctl_tdata    = '0;
        bus.s_axis_ctl_tvalid   = '0;
        bus.s_axis_frame_tdata  = '0;
        bus.s_axis_frame_tvalid = '0;
        bus.m_axis_tready       = 1'b0;
        test_reset;
        test_round_robin;
        test_basic;
        test_drop;
        test_size_zero;
        test_enable;
        test_random;
        test_reset_mid;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/eth_frame_log_arbiter.md
Name: eth_frame_log_arbiter

Overview:
- Merges the per-detector extract streams (120-bit control record plus frame-data words) from C_NUM_SOURCES frame detectors into one log stream, in the log clock domain.
- Grants sources round-robin, one whole record at a time.
- Emits each record as header words (the control record) followed by exactly the frame-data words that the record's SIZE field implies.
- Records with an all-zero MATCHED field (overflow-aborted) are drained from the frame FIFO and counted, never forwarded.

Parameters:
- C_NUM_SOURCES, 2, number of extract units arbitrated (1..8).
- C_NUM_SCRIPTS, 4, width of MATCHED field at ctl bits [C_NUM_SCRIPTS+111:112].
- C_AXIS_LOG_WIDTH, 64, frame/output word width; legal values 32, 64, 128.

Ports:
- clk  in  1  log clock; single clock domain.
- rst  in  1  asynchronous, active-high reset.
- enable  in  1  when low, no new grants; a record in progress completes.
- s_axis_ctl_tdata  in  120*C_NUM_SOURCES  per-source {MATCHED, SIZE[111:96], NUMBER[95:64], TIMESTAMP[63:0]}.
- s_axis_ctl_tvalid  in  C_NUM_SOURCES  per-source valid.
- s_axis_ctl_tready  out  C_NUM_SOURCES  per-source ready.
- s_axis_frame_tdata  in  C_AXIS_LOG_WIDTH*C_NUM_SOURCES  per-source frame words.
- s_axis_frame_tvalid  in  C_NUM_SOURCES  per-source valid.
- s_axis_frame_tready  out  C_NUM_SOURCES  per-source ready.
- m_axis_tdata  out  C_AXIS_LOG_WIDTH  merged log stream.
- m_axis_tdest  out  max(1,$clog2(C_NUM_SOURCES))  index of the granted source.
- m_axis_tlast  out  1  last word of record.
- m_axis_tvalid  out  1  output valid.
- m_axis_tready  in  1  output ready.
- dropped_count  out  32  number of drained (MATCHED==0) records; wraps.

Behaviour:
- Definitions: B = C_AXIS_LOG_WIDTH/8. H = 128/C_AXIS_LOG_WIDTH header words; ctl is zero-extended to 128 bits and sent LSB word first. D = ceil(SIZE/B) data words.
- Reset: state = ST_IDLE; rr_ptr = 0; dropped_count = 0; all tready/tvalid outputs 0; m_axis_tdata, m_axis_tdest and m_axis_tlast = 0.
- Reset mid-record abandons the record; upstream FIFOs are reset separately.
- ST_IDLE:
  - If enable and any ctl_tvalid, grant the first valid source searching from rr_ptr upward, wrapping at C_NUM_SOURCES.
  - s_axis_ctl_tready[g] = 1 for that cycle only (combinational). Latch ctl into hdr_reg, g into grant, D into remaining (16 bits).
  - Next state: ST_HEADER if MATCHED != 0; ST_DRAIN if MATCHED == 0 and D > 0.
  - If MATCHED == 0 and D == 0: stay in ST_IDLE, dropped_count += 1, rr_ptr = g+1 (wrap).
  - Grant-to-first-output latency is 1 cycle.
- ST_HEADER:
  - m_axis_tvalid = 1; tdata = hdr_reg word hidx; tdest = grant.
  - tlast = (hidx == H-1) & (D == 0).
  - On handshake hidx += 1. After word H-1: go to ST_IDLE if D == 0, else ST_DATA.
- ST_DATA (pass-through, zero latency):
  - m_axis_tdata = frame_tdata[grant]; m_axis_tvalid = frame_tvalid[grant]; frame_tready[grant] = m_axis_tready. All other frame_tready = 0.
  - tlast = (remaining == 1).
  - On handshake remaining -= 1; at 1 -> ST_IDLE.
- ST_DRAIN:
  - frame_tready[grant] = 1; m_axis_tvalid = 0.
  - remaining decrements on each frame_tvalid[grant].
  - On the final word: ST_IDLE and dropped_count += 1.
- Pointer update: on return to ST_IDLE from any state, rr_ptr = grant+1, wrapping to 0.
- enable falling mid-record has no effect until ST_IDLE.
- SIZE arithmetic: D = (SIZE + B-1) >> log2(B), computed in 17 bits so SIZE = 0xFFFF does not overflow.
- Frame words beyond D are never consumed for that record; they belong to the next record of the same source.
- ctl_tvalid is never accepted outside ST_IDLE.
- m_axis_tvalid holds and tdata stays stable while m_axis_tready = 0 in ST_HEADER.

Test Plan:
- W=64, source 0 ctl SIZE=20, MATCHED=0x1, 3 frame words -> output: 2 header words, then 3 data words, tlast on 5th, tdest=0.
- Both sources valid continuously, SIZE=8 each -> grants alternate 0,1,0,1; each record is 3 words with tlast on the 3rd.
- Source 1 ctl MATCHED=0, SIZE=17 -> 3 frame words drained; m_axis_tvalid stays 0; dropped_count 0->1; next record from source 1 forwarded intact.
- SIZE=0, MATCHED=0x2 -> exactly 2 header words, tlast on 2nd, no frame_tready pulse; SIZE=0, MATCHED=0 -> no output, dropped_count +1 in 1 cycle.
- Random m_axis_tready 50%, frame_tvalid gaps, SIZE=1..1518 -> word count per record equals H+ceil(SIZE/8), data matches the source sequence, no reordering.
- Assert rst during ST_DATA (remaining=4) -> all outputs 0 the same cycle, rr_ptr=0, state ST_IDLE; enable=0 with pending ctl -> no ctl_tready pulse.
